// File: rtl/utpu_pkg.sv
// utpu_pkg: shared types, sizes and the MAC helper for the micro-TPU
package utpu_pkg;
  localparam int N            = 2;
  localparam int DATA_W       = 8;
  localparam int RES_W        = 16;
  localparam int LOAD_BYTES   = 2 * N * N;
  localparam int RESULT_BYTES = N * N * (RES_W / 8);
  typedef enum logic [1:0] {IDLE, COMPUTE, SEND} state_t;
  typedef logic signed [DATA_W-1:0] operand_t;
  typedef logic signed [RES_W-1:0]  result_t;
  // Two-term dot product; products widened to RES_W, sum wraps at RES_W bits
  function automatic result_t mac2(input operand_t a0, input operand_t a1,
                                   input operand_t w0, input operand_t w1);
    result_t p0, p1;
    p0 = result_t'(a0) * result_t'(w0);
    p1 = result_t'(a1) * result_t'(w1);
    return p0 + p1;
  endfunction
endpackage

// File: rtl/utpu_uart.sv
// utpu_uart: 8N1 UART with rx synchronizer/deserializer and tx serializer,
// byte valid/ready on both sides
module utpu_uart #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  input  logic       i_rx_ready,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic          r_rx_s1, r_rx_s2, r_rx_d, r_rx_busy, r_rx_valid;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          w_rx_tick;
  logic          r_tx_busy, r_tx_line;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [9:0]    r_tx_shift;
  logic          w_tx_end;
  // rx bit 0 is the start bit (checked after half a bit), 1..8 data, 9 stop
  assign w_rx_tick  = r_rx_cnt == ((r_rx_bit == 4'd0) ? HALF : LAST);
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_shift;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      if (i_rx_ready) r_rx_valid <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_d && !r_rx_s2) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= '0;
          r_rx_bit  <= '0;
        end
      end else if (!w_rx_tick) begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end else begin
        r_rx_cnt <= '0;
        r_rx_bit <= r_rx_bit + 1'b1;
        if (r_rx_bit == 4'd0 && r_rx_s2) r_rx_busy <= 1'b0;
        else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          if (r_rx_s2) r_rx_valid <= 1'b1;
        end else if (r_rx_bit != 4'd0) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
      end
    end
  end
  // Ready in the last stop-bit cycle lets the next frame follow with no gap
  assign w_tx_end   = r_tx_busy && r_tx_bit == 4'd9 && r_tx_cnt == LAST;
  assign o_tx_ready = !r_tx_busy || w_tx_end;
  assign o_tx       = r_tx_line;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_busy  <= 1'b0;
      r_tx_line  <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '1;
    end else begin
      r_tx_line <= !r_tx_busy || r_tx_shift[0];
      if (i_tx_valid && o_tx_ready) begin
        r_tx_busy  <= 1'b1;
        r_tx_shift <= {1'b1, i_tx_data, 1'b0};
        r_tx_cnt   <= '0;
        r_tx_bit   <= '0;
      end else if (r_tx_busy) begin
        if (r_tx_cnt == LAST) begin
          r_tx_cnt <= '0;
          if (r_tx_bit == 4'd9) r_tx_busy <= 1'b0;
          else begin
            r_tx_bit   <= r_tx_bit + 1'b1;
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
          end
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/utpu_top.sv
// utpu_top: micro-TPU loading 2x2 int8 A and W over UART, computing C = A*W
// and streaming the four 16-bit results back over UART
module utpu_top
  import utpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic rx,
  output logic tx
);
  state_t     r_state, w_state_nxt;
  operand_t   r_a [N*N];
  operand_t   r_w [N*N];
  result_t    r_c [N*N];
  logic [2:0] r_load_cnt;
  logic [1:0] r_mac_idx;
  logic [3:0] r_tx_idx;
  logic       w_rx_valid, w_tx_valid, w_tx_ready;
  logic [7:0] w_rx_data, w_tx_data;
  result_t    w_mac, w_c_cur;
  utpu_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk       (clk),
    .rst       (rst),
    .i_rx      (rx),
    .o_rx_valid(w_rx_valid),
    .o_rx_data (w_rx_data),
    .i_rx_ready(1'b1),
    .i_tx_valid(w_tx_valid),
    .i_tx_data (w_tx_data),
    .o_tx_ready(w_tx_ready),
    .o_tx      (tx)
  );
  always_comb begin
    w_state_nxt = (r_state == IDLE && start)                      ? COMPUTE :
                  (r_state == COMPUTE && r_mac_idx == 2'd3)       ? SEND    :
                  (r_state == SEND && r_tx_idx[3] && w_tx_ready)  ? IDLE    : r_state;
    w_mac      = mac2(r_a[{r_mac_idx[1], 1'b0}], r_a[{r_mac_idx[1], 1'b1}],
                      r_w[{1'b0, r_mac_idx[0]}], r_w[{1'b1, r_mac_idx[0]}]);
    w_c_cur    = r_c[r_tx_idx[2:1]];
    w_tx_data  = r_tx_idx[0] ? w_c_cur[15:8] : w_c_cur[7:0];
    w_tx_valid = r_state == SEND && !r_tx_idx[3];
  end
  // Buffers only change in IDLE, so they act as the compute-entry snapshot;
  // a byte landing on the start cycle is written and thus included
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_load_cnt <= '0;
      r_mac_idx  <= '0;
      r_tx_idx   <= '0;
      for (int k = 0; k < N*N; k++) begin
        r_a[k] <= '0;
        r_w[k] <= '0;
        r_c[k] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_rx_valid && r_state == IDLE) begin
        if (r_load_cnt[2]) r_w[r_load_cnt[1:0]] <= w_rx_data;
        else r_a[r_load_cnt[1:0]] <= w_rx_data;
        r_load_cnt <= r_load_cnt + 1'b1;
      end
      if (r_state == COMPUTE) begin
        r_c[r_mac_idx] <= w_mac;
        r_mac_idx      <= r_mac_idx + 1'b1;
      end
      r_tx_idx <= (r_state == COMPUTE) ? 4'd0 : r_tx_idx + 4'(w_tx_valid && w_tx_ready);
    end
  end
endmodule

// File: tb/tb_utpu_top.sv
// tb_utpu_top: randomized and directed UART-level scoreboard bench for utpu_top
module tb_utpu_top;
  localparam int CPB = 16;
  typedef logic signed [7:0] op_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rx = 1'b1;
  logic tx;
  int checks = 0, failures = 0;
  int rx_bytes = 0;
  bit mon_busy = 0;
  longint cyc = 0, last_rst = -1000;
  logic [7:0] sb[$];

  utpu_top #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .start(start), .rx(rx), .tx(tx));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) last_rst <= cyc;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: decode each tx frame at mid-bit and compare with the scoreboard
  initial begin
    logic [7:0] b, e;
    logic ok;
    longint fs;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mon_busy = 1;
        fs = cyc;
        repeat (CPB/2) @(negedge clk);
        ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        ok = ok && (tx === 1'b1);
        if (last_rst < fs) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL tx_byte: got unexpected byte 0x%02h required no byte", b);
          end else begin
            e = sb.pop_front();
            rx_bytes++;
            if (!ok || b !== e) begin
              failures++;
              $display("FAIL tx_byte: got 0x%02h framing_ok=%0d required 0x%02h", b, ok, e);
            end
          end
        end
        mon_busy = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic load(input op_t a[4], input op_t w[4]);
    for (int i = 0; i < 4; i++) send_byte(a[i]);
    for (int i = 0; i < 4; i++) send_byte(w[i]);
  endtask

  // Reference model: plain integer matrix product, low 16 bits, lo byte first
  task automatic expect_txn(input op_t a[4], input op_t w[4]);
    int c;
    logic [15:0] c16;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        c = int'(a[2*i]) * int'(w[j]) + int'(a[2*i+1]) * int'(w[2+j]);
        c16 = c[15:0];
        sb.push_back(c16[7:0]);
        sb.push_back(c16[15:8]);
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_txn(input bit extra_start = 1'b0);
    int base, lat;
    longint t0;
    base = rx_bytes;
    pulse_start();
    t0 = cyc;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        lat = k;
        break;
      end
    end
    check("start_to_tx_latency", lat, 6);
    if (extra_start) begin
      repeat (300) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 2000 && (sb.size() != 0 || mon_busy); k++) @(negedge clk);
    check("txn_done_by_1300", int'(cyc - t0 <= 1300), 1);
    repeat (40) @(negedge clk);
    check("bytes_out", rx_bytes - base, 8);
    check("tx_idle_after_txn", int'(tx), 1);
  endtask

  initial begin
    op_t a[4], w[4], z[4];
    int lows, base;
    z = '{0, 0, 0, 0};
    repeat (3) @(negedge clk);
    check("tx_in_reset", int'(tx), 1);
    rst = 1'b0;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("idle_tx_low_cycles", lows, 0);

    expect_txn(z, z);
    run_txn();

    a = '{1, 2, 3, 4};     w = '{5, 6, 7, 8};
    load(a, w); expect_txn(a, w); run_txn();
    a = '{-1, 0, 0, 1};    w = '{2, 3, 4, 5};
    load(a, w); expect_txn(a, w); run_txn();
    a = '{-128, -128, -128, -128}; w = a;
    load(a, w); expect_txn(a, w); run_txn();

    // Framing-error byte mid-load is dropped; extra start during SEND ignored
    a = '{2, -3, 4, 5};    w = '{6, 7, -8, 9};
    for (int i = 0; i < 3; i++) send_byte(a[i]);
    send_byte(8'h5A, 1'b0);
    send_byte(a[3]);
    for (int i = 0; i < 4; i++) send_byte(w[i]);
    expect_txn(a, w); run_txn(1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        a[i] = op_t'($urandom_range(0, 255));
        w[i] = op_t'($urandom_range(0, 255));
      end
      load(a, w); expect_txn(a, w); run_txn();
    end
    expect_txn(a, w); run_txn();

    // Reset during the third transmitted byte
    a = '{11, -22, 33, -44}; w = '{55, -66, 77, -88};
    load(a, w); expect_txn(a, w);
    base = rx_bytes;
    pulse_start();
    for (int k = 0; k < 1000 && !(rx_bytes == base + 2 && mon_busy); k++) @(negedge clk);
    check("reached_third_byte", rx_bytes - base, 2);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("tx_high_after_rst", int'(tx), 1);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    repeat (200) @(negedge clk);
    expect_txn(z, z);
    run_txn();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
